// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch unit: PC sequencing, one-cycle imem read, FWFT decode queue
module fetch_queue #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      redirect,
    input  logic [ADDR_W-1:0]         redirect_pc,
    output logic                      imem_req,
    output logic [ADDR_W-1:0]         imem_addr,
    input  logic [DATA_W-1:0]         imem_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_instr,
    output logic [ADDR_W-1:0]         out_next_pc,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int                PTR_W = $clog2(DEPTH);
    localparam int                CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] tag;
    logic              inflight;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] mem_instr [DEPTH];
    logic [ADDR_W-1:0] mem_npc   [DEPTH];
    logic              pop;
    logic              push;
    logic [CNT_W:0]    occupancy;

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // A redirect kills the response landing this cycle along with the queue.
    assign push      = inflight & ~redirect;

    // Entries held plus the one still in flight must fit after this cycle's pop.
    assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    assign imem_req  = rst & en & ~redirect & (occupancy < (CNT_W+1)'(DEPTH));
    assign imem_addr = pc;

    assign out_instr   = out_valid ? mem_instr[rd_ptr] : '0;
    assign out_next_pc = out_valid ? mem_npc[rd_ptr]   : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            tag      <= '0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (imem_req) begin
                pc  <= pc + STEP;
                tag <= pc;
            end
            inflight <= imem_req;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= imem_rdata;
            mem_npc[wr_ptr]   <= tag + STEP;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized fetch_queue bench against a list-based model, three configurations
module tb_fetch_queue;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        redirect = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        ireq   [N];
    logic [31:0] iaddr  [N];
    logic [31:0] rdata  [N];
    logic        ovalid [N];
    logic [31:0] oinstr [N];
    logic [31:0] onpc   [N];
    logic [31:0] ocnt   [N];

    logic [2:0]  c0;
    logic [1:0]  c1;
    logic [3:0]  c2;
    logic [7:0]  a1, n1;
    logic [15:0] a2, n2;

    int npass = 0;
    int ncheck = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .PC_STEP(4)) u_d4 (
        .clk(clk), .rst(rst), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(ireq[0]), .imem_addr(iaddr[0]), .imem_rdata(rdata[0]),
        .out_valid(ovalid[0]), .out_ready(out_ready), .out_instr(oinstr[0]),
        .out_next_pc(onpc[0]), .count(c0)
    );

    fetch_queue #(.DATA_W(32), .ADDR_W(8), .DEPTH(2), .PC_STEP(4)) u_d2 (
        .clk(clk), .rst(rst), .en(en), .redirect(redirect), .redirect_pc(redirect_pc[7:0]),
        .imem_req(ireq[1]), .imem_addr(a1), .imem_rdata(rdata[1]),
        .out_valid(ovalid[1]), .out_ready(out_ready), .out_instr(oinstr[1]),
        .out_next_pc(n1), .count(c1)
    );

    fetch_queue #(.DATA_W(32), .ADDR_W(16), .DEPTH(8), .PC_STEP(4)) u_d8 (
        .clk(clk), .rst(rst), .en(en), .redirect(redirect), .redirect_pc(redirect_pc[15:0]),
        .imem_req(ireq[2]), .imem_addr(a2), .imem_rdata(rdata[2]),
        .out_valid(ovalid[2]), .out_ready(out_ready), .out_instr(oinstr[2]),
        .out_next_pc(n2), .count(c2)
    );

    assign ocnt[0]  = {29'b0, c0};
    assign ocnt[1]  = {30'b0, c1};
    assign ocnt[2]  = {28'b0, c2};
    assign iaddr[1] = {24'b0, a1};
    assign iaddr[2] = {16'b0, a2};
    assign onpc[1]  = {24'b0, n1};
    assign onpc[2]  = {16'b0, n2};

    function automatic int dep(int i);
        return (i == 0) ? 4 : ((i == 1) ? 2 : 8);
    endfunction

    function automatic logic [63:0] amask(int i);
        int w;
        w = (i == 0) ? 32 : ((i == 1) ? 8 : 16);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [31:0] rom(logic [63:0] a);
        logic [31:0] t;
        t = a[31:0];
        return t >> 2;
    endfunction

    task automatic chk(string nm, int inst, logic [63:0] got, logic [63:0] exp);
        ncheck++;
        if (got === exp) npass++;
        else $display("FAIL %s inst%0d got=%0h expected=%0h t=%0t", nm, inst, got, exp, $time);
    endtask

    // Model: fetch address list per instance, in-flight tag, PC
    logic [63:0] m_pc  [N];
    logic        m_inf [N];
    logic [63:0] m_tag [N];
    logic [63:0] m_q   [N][16];
    int          m_len [N];

    logic        d_req [N];
    logic        d_pop [N];
    logic        d_redir;
    logic [63:0] d_rpc;
    logic        p_req  [N];
    logic [31:0] p_addr [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            p_req[i] = 1'b0;
            p_addr[i] = '0;
            d_req[i] = 1'b0;
            d_pop[i] = 1'b0;
        end
        d_redir = 1'b0;
        d_rpc = '0;
    end

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < N; i++) begin
            if (!rst) begin
                m_pc[i] = '0;
                m_inf[i] = 1'b0;
                m_tag[i] = '0;
                m_len[i] = 0;
            end else if (d_redir) begin
                m_pc[i] = d_rpc & amask(i);
                m_inf[i] = 1'b0;
                m_len[i] = 0;
            end else begin
                if (d_pop[i]) begin
                    for (int k = 0; k < 15; k++) m_q[i][k] = m_q[i][k+1];
                    m_len[i] = m_len[i] - 1;
                end
                if (m_inf[i]) begin
                    m_q[i][m_len[i]] = m_tag[i];
                    m_len[i] = m_len[i] + 1;
                end
                if (d_req[i]) begin
                    m_tag[i] = m_pc[i];
                    m_pc[i] = (m_pc[i] + 64'd4) & amask(i);
                end
                m_inf[i] = d_req[i];
            end
        end
    end

    always @(negedge clk) begin
        logic        e_valid;
        logic        e_pop;
        logic        e_req;
        int          occ;
        for (int i = 0; i < N; i++) begin
            rdata[i] = p_req[i] ? rom({32'b0, p_addr[i]}) : $urandom;
            e_valid = (m_len[i] != 0);
            e_pop = e_valid & out_ready;
            occ = m_len[i] + int'(m_inf[i]) - int'(e_pop);
            e_req = rst & en & ~redirect & (occ < dep(i));
            chk("out_valid", i, {63'b0, ovalid[i]}, {63'b0, e_valid});
            chk("count", i, {32'b0, ocnt[i]}, 64'(m_len[i]));
            chk("count_le_depth", i, {63'b0, (ocnt[i] <= 32'(dep(i)))}, 64'd1);
            chk("imem_req", i, {63'b0, ireq[i]}, {63'b0, e_req});
            chk("imem_addr", i, {32'b0, iaddr[i]}, m_pc[i]);
            if (e_valid) begin
                chk("out_instr", i, {32'b0, oinstr[i]}, {32'b0, rom(m_q[i][0])});
                chk("out_next_pc", i, {32'b0, onpc[i]}, (m_q[i][0] + 64'd4) & amask(i));
            end else begin
                chk("out_instr_idle", i, {32'b0, oinstr[i]}, 64'd0);
                chk("out_next_pc_idle", i, {32'b0, onpc[i]}, 64'd0);
            end
            d_req[i] = e_req;
            d_pop[i] = e_pop;
            p_req[i] = ireq[i];
            p_addr[i] = iaddr[i];
        end
        d_redir = redirect;
        d_rpc = {32'b0, redirect_pc};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; out_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        repeat (3) step();
        #1;
        chk("lit_rst_valid", 0, {63'b0, ovalid[0]}, 64'd0);
        chk("lit_rst_req", 0, {63'b0, ireq[0]}, 64'd0);
        chk("lit_rst_addr", 0, {32'b0, iaddr[0]}, 64'd0);

        // sustained fetch after release
        step(); rst = 1'b1; #1;
        chk("lit_c0_req", 0, {63'b0, ireq[0]}, 64'd1);
        chk("lit_c0_addr", 0, {32'b0, iaddr[0]}, 64'd0);
        step(); #1;
        chk("lit_c1_addr", 0, {32'b0, iaddr[0]}, 64'd4);
        step(); #1;
        chk("lit_c2_valid", 0, {63'b0, ovalid[0]}, 64'd1);
        chk("lit_c2_instr", 0, {32'b0, oinstr[0]}, 64'd0);
        chk("lit_c2_npc", 0, {32'b0, onpc[0]}, 64'd4);
        step(); #1;
        chk("lit_c3_instr", 0, {32'b0, oinstr[0]}, 64'd1);
        chk("lit_c3_npc", 0, {32'b0, onpc[0]}, 64'd8);
        chk("lit_c3_addr", 0, {32'b0, iaddr[0]}, 64'd12);

        // 10-cycle stall fills the queue
        step(); out_ready = 1'b0;
        repeat (9) step();
        #1;
        chk("lit_stall_count", 0, {32'b0, ocnt[0]}, 64'd4);
        chk("lit_stall_req", 0, {63'b0, ireq[0]}, 64'd0);
        step(); out_ready = 1'b1;
        repeat (8) step();

        // redirect with three queued and one in flight
        step(); out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0;
        step(); redirect = 1'b0;
        repeat (4) step();
        #1;
        chk("lit_pre_redir_count", 0, {32'b0, ocnt[0]}, 64'd3);
        chk("lit_pre_redir_req", 0, {63'b0, ireq[0]}, 64'd0);
        redirect = 1'b1; redirect_pc = 32'h40;
        step(); redirect = 1'b0; out_ready = 1'b1; #1;
        chk("lit_redir_count", 0, {32'b0, ocnt[0]}, 64'd0);
        chk("lit_redir_addr", 0, {32'b0, iaddr[0]}, 64'h40);
        chk("lit_redir_valid1", 0, {63'b0, ovalid[0]}, 64'd0);
        step(); #1;
        chk("lit_redir_valid2", 0, {63'b0, ovalid[0]}, 64'd0);
        step(); #1;
        chk("lit_redir_instr", 0, {32'b0, oinstr[0]}, 64'h10);
        chk("lit_redir_npc", 0, {32'b0, onpc[0]}, 64'h44);

        // 8-bit address wrap
        step(); redirect = 1'b1; redirect_pc = 32'hFC;
        step(); redirect = 1'b0; #1;
        chk("lit_wrap_addr0", 1, {32'b0, iaddr[1]}, 64'hFC);
        step(); #1;
        chk("lit_wrap_addr1", 1, {32'b0, iaddr[1]}, 64'h00);
        step(); #1;
        chk("lit_wrap_instr", 1, {32'b0, oinstr[1]}, 64'h3F);
        chk("lit_wrap_npc", 1, {32'b0, onpc[1]}, 64'h00);

        // asynchronous reset mid-stream with two queued
        step(); out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0;
        step(); redirect = 1'b0;
        repeat (3) step();
        #1;
        chk("lit_prerst_count", 0, {32'b0, ocnt[0]}, 64'd2);
        rst = 1'b0; #1;
        chk("lit_async_valid", 0, {63'b0, ovalid[0]}, 64'd0);
        chk("lit_async_count", 0, {32'b0, ocnt[0]}, 64'd0);
        chk("lit_async_instr", 0, {32'b0, oinstr[0]}, 64'd0);
        step(); step(); rst = 1'b1; out_ready = 1'b1; #1;
        chk("lit_restart_req", 0, {63'b0, ireq[0]}, 64'd1);
        chk("lit_restart_addr", 0, {32'b0, iaddr[0]}, 64'd0);

        // random traffic
        for (int c = 0; c < 2000; c++) begin
            step();
            en = ($urandom_range(0, 9) != 0);
            out_ready = $urandom_range(0, 1) == 1;
            redirect = ($urandom_range(0, 39) == 0);
            redirect_pc = $urandom & 32'hFFFF_FFFC;
            rst = ($urandom_range(0, 299) != 0);
        end
        step(); rst = 1'b1; redirect = 1'b0;
        step();
        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 32: instruction word width.
REQ-002 The block SHALL provide parameter ADDR_W, default 32: PC and instruction-memory address width.
REQ-003 The block SHALL provide parameter DEPTH, default 4: queue entries, a power of two, at least 2.
REQ-004 The block SHALL provide parameter PC_STEP, default 4: PC increment per fetched instruction.
REQ-005 The block SHALL provide parameter RESET_PC, default 0: PC value loaded at reset.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-007 The block SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-008 The block SHALL provide port rst  input  1  asynchronous reset, active-low (0 = reset).
REQ-009 The block SHALL provide port en  input  1  fetch enable; 0 = issue no new memory requests.
REQ-010 The block SHALL provide port redirect  input  1  branch/flush request.
REQ-011 The block SHALL provide port redirect_pc  input  ADDR_W  new fetch address, valid with redirect.
REQ-012 The block SHALL provide port imem_req  output  1  instruction-memory read strobe.
REQ-013 The block SHALL provide port imem_addr  output  ADDR_W  read address; equals current PC.
REQ-014 The block SHALL provide port imem_rdata  input  DATA_W  read data, valid exactly one cycle after imem_req.
REQ-015 The block SHALL provide port out_valid  output  1  head entry available to decode.
REQ-016 The block SHALL provide port out_ready  input  1  decode accepts head entry.
REQ-017 The block SHALL provide port out_instr  output  DATA_W  head instruction word.
REQ-018 The block SHALL provide port out_next_pc  output  ADDR_W  head instruction's fetch address + PC_STEP.
REQ-019 The block SHALL provide port count  output  clog2(DEPTH)+1  number of valid queue entries.

Function
REQ-020 The pop condition SHALL be pop = out_valid & out_ready; out_valid = (count != 0); head is first-word-fall-through.
REQ-021 imem_req SHALL be combinational: rst & en & !redirect & (count + inflight - pop < DEPTH).
REQ-022 On each issued request the PC SHALL advance by PC_STEP modulo 2^ADDR_W, and inflight SHALL be set with tag = issued PC; otherwise inflight clears after its response cycle.
REQ-023 In the cycle after an issue, unless killed, {imem_rdata, tag + PC_STEP} SHALL be written to the queue tail at the closing edge.
REQ-024 Latency SHALL be: imem_req in cycle C, so out_valid is high in cycle C+2 with that instruction.
REQ-025 Throughput SHALL be sustained 1 instruction/cycle when en=1, out_ready=1, and no redirect, for any DEPTH >= 2.
REQ-026 On a simultaneous push and pop, count SHALL be unchanged and order preserved; pointers SHALL wrap modulo DEPTH.
REQ-027 The queue SHALL never overflow; no response is ever dropped except by redirect/reset.
REQ-028 A pop with count=0 SHALL be impossible; out_ready while out_valid=0 SHALL have no effect.
REQ-029 While out_valid=1 and out_ready=0, out_instr/out_next_pc SHALL hold stable.
REQ-030 On redirect=1 in a cycle: PC<=redirect_pc, count<=0, pointers<=0, the in-flight response arriving next cycle SHALL be discarded, and imem_req=0 in that cycle.
REQ-031 Redirect SHALL take priority over a simultaneous push and pop; the entry presented in that cycle counts as consumed if out_ready=1.
REQ-032 The first request after redirect SHALL occur the next cycle at redirect_pc (if en=1); out_valid SHALL be low for at least 2 cycles after redirect.
REQ-033 With en=0, no new requests SHALL issue; an outstanding response is still captured; the output handshake continues.
REQ-034 Back-to-back redirects SHALL each take effect; the last one wins.

Reset
REQ-035 While rst=0: PC=RESET_PC, count=0, inflight=0, pointers=0, out_valid=0, imem_req=0, out_instr=0, out_next_pc=0, imem_addr=RESET_PC.
REQ-036 Reset asserted mid-operation SHALL discard all queued and in-flight data immediately (asynchronously).
REQ-037 The first request SHALL issue in the first rising edge's cycle after rst goes 1, at RESET_PC.

Verification
REQ-038 Reset release, en=1, out_ready=1, ROM word k = k: imem_addr 0,4,8,... each cycle; out_instr 0,1,2,... one per cycle from 2 cycles later; out_next_pc 4,8,12.
REQ-039 out_ready=0 for 10 cycles, DEPTH=4: count rises to 4, imem_req drops, no data lost; on release, words emerge in order with no gap or duplicate.
REQ-040 redirect with redirect_pc=0x40 while count=3 and a request is in flight: next cycle count=0, imem_addr=0x40; first output is word at 0x40 with out_next_pc=0x44; the stale response never appears.
REQ-041 Toggle out_ready randomly for 1000 cycles (DEPTH=2 and 8): output sequence equals address order; out_instr stable while stalled; count never exceeds DEPTH.
REQ-042 Assert rst=0 mid-stream with count=2: outputs clear without a clock edge; after release, fetch restarts at RESET_PC.
REQ-043 ADDR_W=8, PC at 0xFC: the next issued address is 0x00 (wrap); out_next_pc of the 0xFC word is 0x00.
